uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver: the receive-side counterpart of the UART transmitter and its `baud_gen`. It synchronises the asynchronous `rx` line, detects and validates start bits using a 16x oversampling tick, and samples each data bit at mid-bit. Bytes are assembled LSB first and delivered on a valid/ready handshake. The block sits between the board `rx` pin and the SoC byte consumer (FIFO or CPU register).

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in bit/s.
- `OVERSAMPLE`, default 16: ticks per bit. Must be even and ≥ 4.
- `DATA_BITS`, default 8: data bits per frame. Range 5–8.
- `clk` input 1: system clock, all logic on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rx` input 1: serial line, idle high, asynchronous to `clk`.
- `rx_data` output DATA_BITS: received byte, LSB = first bit on the line.
- `rx_valid` output 1: `rx_data` holds an unconsumed byte.
- `rx_ready` input 1: consumer accepts the byte when `rx_valid && rx_ready`.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `parity_err` output 1: one-cycle pulse on parity mismatch. Tied 0 when parity is compiled out.
- `overrun_err` output 1: one-cycle pulse when a good byte is dropped because `rx_valid` is still set.

## Operation
- `rx` passes through a 2-flop synchroniser; both flops reset to 1. A third flop (`rx_prev`, reset 1) is used for edge detection.
- Tick generator: DIVISOR = CLK_FREQ / (BAUD_RATE*OVERSAMPLE), integer truncation (651 at defaults).
  - Counts 0..DIVISOR-1 and pulses `tick` for one cycle at DIVISOR-1.
  - Forced to 0 on the start-edge cycle, so bit timing is aligned to the detected edge.
- State machine (`IDLE`, `START`, `DATA`, [`PARITY`], `STOP`), with `tcnt` counting ticks within a state:
  - `IDLE`: a synced falling edge (`rx_prev`=1, synced `rx`=0) moves to `START` and clears `tcnt` and the tick generator. A line held low does not count as a start.
  - `START`: on tick number OVERSAMPLE/2 (8th tick), sample the line.
    - 1: false start, return to `IDLE`, no error flagged.
    - 0: clear `tcnt` and go to `DATA`.
  - `DATA`: every OVERSAMPLE ticks, sample and shift the bit in (right-shift, MSB entry). After DATA_BITS samples, go to `PARITY` if compiled in, otherwise `STOP`.
  - `PARITY`: sample after OVERSAMPLE ticks, then go to `STOP`.
  - `STOP`: sample after OVERSAMPLE ticks, then return to `IDLE` in the same cycle. This is mid-stop-bit, so the next start edge can be caught.
- Stop-sample outcomes, each registered on the cycle after the sample:
  - Stop = 0: `frame_err` pulses and the byte is discarded.
  - Parity bad: `parity_err` pulses and the byte is discarded. If both faults occur, both pulse.
  - Good frame with `rx_valid`=0, or with `rx_valid && rx_ready` in that same cycle: load `rx_data` and set `rx_valid`.
  - Good frame with `rx_valid`=1 and `rx_ready`=0: `overrun_err` pulses, the new byte is dropped, and `rx_data` is kept.
- `rx_valid` clears on the cycle after `rx_valid && rx_ready`. `rx_data` stays stable while `rx_valid`=1.
- Reset values: `rx_data`=0, `rx_valid`=0, all error outputs 0, state `IDLE`, counters 0.
- Reset mid-frame: the partial byte is discarded. After release, a new start needs an observed 1→0 transition.

## Timing
- Synchroniser latency is 2 clocks from the `rx` pin to edge detection.
- Start validation occurs OVERSAMPLE/2 ticks after detection. Data bit k is sampled (OVERSAMPLE/2 + (k+1)*OVERSAMPLE) ticks after detection.
- 8N1 at defaults: stop sampled at 152 ticks (152*651 = 98 952 clocks after detection). `rx_valid` rises 1 clock later.
- Error pulses are exactly 1 clock wide. Back-to-back frames with no idle gap are supported.

## Configuration
- `UART_RX_PARITY_EN` defined: the `PARITY` state is compiled in, even parity is checked, and a frame is 1+DATA_BITS+1+1 bits.
- Not defined: no `PARITY` state, `parity_err` is constant 0, and a frame is 1+DATA_BITS+1 bits.

## Structure
- Shared package `uart_pkg`:
  - `rx_state_t` enum.
  - A function computing DIVISOR from CLK_FREQ, BAUD_RATE and OVERSAMPLE.
  - Line idle-level constant (1).
- Sub-module `uart_rx_tick_gen`: oversampling tick counter with synchronous `clear` input, parameterised by DIVISOR.

## Test plan
Bench parameters: CLK_FREQ=1_600_000, BAUD_RATE=10_000 (DIVISOR=10, 160 clocks/bit), parity off unless stated.
- Send 0xA5 (8N1), `rx_ready`=1 → `rx_valid` pulses 1 clock with `rx_data`=0xA5, 1 521 clocks after the synced edge; no errors.
- Glitch `rx` low for 40 clocks → no `rx_valid`, no error, FSM back in `IDLE`.
- Send 0x3C with stop bit driven 0 → `frame_err` pulses once, `rx_valid` stays 0; next valid frame 0x55 is received correctly.
- Hold `rx_ready`=0, send 0x11 then 0x22 back-to-back → `rx_data`=0x11 held, `overrun_err` pulses at the second stop; raise ready → `rx_valid` drops, 0x22 is never delivered.
- `UART_RX_PARITY_EN`: send 0x07 with parity bit 0 → `parity_err` pulse, no `rx_valid`; with parity bit 1 → 0x07 delivered.
- Assert `rst` mid data bit 4 while `rx` is low → all outputs 0; release with `rx` low → no reception until `rx` goes high then low.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receiver types and constants.
// Used by uart_rx and uart_rx_tick_gen.
package uart_pkg;

  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic int calc_divisor(
    input int clk_freq,
    input int baud_rate,
    input int oversample
  );
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversampling tick generator: one-cycle tick every DIVISOR clocks.
// Synchronous clear realigns the phase to a detected start edge.
module uart_rx_tick_gen #(
  parameter int DIVISOR = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o
);

  localparam int W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [W-1:0] LAST = W'(DIVISOR - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, LSB first, valid/ready output.
// Define UART_RX_PARITY_EN to add an even-parity bit to each frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam int DIVISOR = calc_divisor(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] OS_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic       sync1_q;
  logic       rx_s;
  logic       prev_q;
  logic [2:0] fill_q;
  logic       rx_fall;

  // fill_q marks when rx_prev holds a real line sample rather than its
  // reset value, so a line held low across reset is never taken as a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= LINE_IDLE;
      rx_s    <= LINE_IDLE;
      prev_q  <= LINE_IDLE;
      fill_q  <= '0;
    end else begin
      sync1_q <= rx;
      rx_s    <= sync1_q;
      prev_q  <= rx_s;
      fill_q  <= {fill_q[1:0], 1'b1};
    end
  end

  assign rx_fall = fill_q[2] & prev_q & ~rx_s;

  logic tick;
  logic tick_clr;

  uart_rx_tick_gen #(
    .DIVISOR(DIVISOR)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clear_i(tick_clr),
    .tick_o (tick)
  );

  rx_state_t state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 oerr_q, oerr_d;
  logic                 par_bad;
  logic                 perr_d;
  logic                 s_last;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic perr_q;
  assign par_bad    = ^{shreg_q, par_q};
  assign parity_err = perr_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign s_last = tick && (tcnt_q == OS_LAST);

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    bcnt_d   = bcnt_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ferr_d   = 1'b0;
    perr_d   = 1'b0;
    oerr_d   = 1'b0;
    tick_clr = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
`endif
    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
    if (tick && !s_last) begin
      tcnt_d = tcnt_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (rx_fall) begin
          state_d  = START;
          tcnt_d   = '0;
          tick_clr = 1'b1;
        end
      end
      START: begin
        if (tick && tcnt_q == HALF_LAST) begin
          tcnt_d  = '0;
          bcnt_d  = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (s_last) begin
          tcnt_d  = '0;
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_last) begin
          tcnt_d  = '0;
          par_d   = rx_s;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (s_last) begin
          tcnt_d  = '0;
          state_d = IDLE;
          ferr_d  = ~rx_s;
          perr_d  = par_bad;
          if (rx_s && !par_bad) begin
            if (!valid_q || rx_ready) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              oerr_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end
`endif

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 160 clocks per bit (DIVISOR 10).
// Honors UART_RX_PARITY_EN when the design is built with it.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD = 10_000;
  localparam int OS = 16;
  localparam int DB = 8;
  localparam int BITC = 160;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 1683;
`else
  localparam int LAT = 1523;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          frame_err;
  logic          parity_err;
  logic          overrun_err;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD),
    .OVERSAMPLE(OS),
    .DATA_BITS (DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  int n_acc = 0;
  int n_vh = 0;
  int n_fe = 0;
  int n_pe = 0;
  int n_oe = 0;
  int rise_cyc = 0;
  int start_cyc = 0;
  logic [DB-1:0] last_data = '0;
  logic v_prev = 1'b0;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      n_acc++;
      last_data = rx_data;
    end
    if (rx_valid) n_vh++;
    if (rx_valid && !v_prev) rise_cyc = cyc;
    v_prev = rx_valid;
    if (frame_err) n_fe++;
    if (parity_err) n_pe++;
    if (overrun_err) n_oe++;
  end

  int s_acc, s_vh, s_fe, s_pe, s_oe;

  task automatic snap();
    s_acc = n_acc;
    s_vh = n_vh;
    s_fe = n_fe;
    s_pe = n_pe;
    s_oe = n_oe;
  endtask

  task automatic bit_out(input logic b);
    rx = b;
    repeat (BITC) @(negedge clk);
  endtask

  task automatic send_frame(
    input logic [7:0] d,
    input logic       stop_b,
    input logic       bad_par
  );
    logic p;
    p = (^d) ^ bad_par;
    start_cyc = cyc;
    bit_out(1'b0);
    for (int i = 0; i < DB; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_out(p);
`endif
    bit_out(stop_b);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b want 0", rx_valid);
    end
    n_checks++;
    if (rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 00", rx_data);
    end
    n_checks++;
    if ({frame_err, parity_err, overrun_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_errs: got %b want 000",
               {frame_err, parity_err, overrun_err});
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_basic();
    snap();
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    n_checks++;
    if (n_acc - s_acc !== 1) begin
      n_fail++;
      $display("FAIL basic_count: got %0d want 1", n_acc - s_acc);
    end
    n_checks++;
    if (last_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL basic_data: got %h want a5", last_data);
    end
    n_checks++;
    if (rise_cyc - start_cyc !== LAT) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d want %0d",
               rise_cyc - start_cyc, LAT);
    end
    n_checks++;
    if (n_vh - s_vh !== 1) begin
      n_fail++;
      $display("FAIL basic_width: got %0d want 1", n_vh - s_vh);
    end
    n_checks++;
    if (n_fe + n_pe + n_oe - s_fe - s_pe - s_oe !== 0) begin
      n_fail++;
      $display("FAIL basic_errs: got %0d want 0",
               n_fe + n_pe + n_oe - s_fe - s_pe - s_oe);
    end
  endtask

  task automatic test_glitch();
    snap();
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    n_checks++;
    if (n_vh - s_vh !== 0) begin
      n_fail++;
      $display("FAIL glitch_valid: got %0d want 0", n_vh - s_vh);
    end
    n_checks++;
    if (n_fe + n_pe + n_oe - s_fe - s_pe - s_oe !== 0) begin
      n_fail++;
      $display("FAIL glitch_errs: got %0d want 0",
               n_fe + n_pe + n_oe - s_fe - s_pe - s_oe);
    end
    n_checks++;
    if (dut.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL glitch_state: got %0d want IDLE", dut.state_q);
    end
  endtask

  task automatic test_frame_err();
    snap();
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (BITC) @(negedge clk);
    n_checks++;
    if (n_fe - s_fe !== 1) begin
      n_fail++;
      $display("FAIL ferr_pulse: got %0d want 1", n_fe - s_fe);
    end
    n_checks++;
    if (n_vh - s_vh !== 0) begin
      n_fail++;
      $display("FAIL ferr_valid: got %0d want 0", n_vh - s_vh);
    end
    snap();
    send_frame(8'h55, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    n_checks++;
    if (n_acc - s_acc !== 1 || last_data !== 8'h55) begin
      n_fail++;
      $display("FAIL ferr_next: got %0d/%h want 1/55",
               n_acc - s_acc, last_data);
    end
  endtask

  task automatic test_overrun();
    rx_ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    n_checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      n_fail++;
      $display("FAIL ovr_hold: got %b/%h want 1/11", rx_valid, rx_data);
    end
    n_checks++;
    if (n_oe - s_oe !== 1) begin
      n_fail++;
      $display("FAIL ovr_pulse: got %0d want 1", n_oe - s_oe);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_drop: got %b want 0", rx_valid);
    end
    repeat (200) @(negedge clk);
    n_checks++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h11) begin
      n_fail++;
      $display("FAIL ovr_lost: got %b/%h want 0/11", rx_valid, rx_data);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (40) @(negedge clk);
    n_checks++;
    if (n_pe - s_pe !== 1 || n_vh - s_vh !== 0) begin
      n_fail++;
      $display("FAIL par_bad: got %0d/%0d want 1/0",
               n_pe - s_pe, n_vh - s_vh);
    end
    snap();
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    n_checks++;
    if (n_acc - s_acc !== 1 || last_data !== 8'h07) begin
      n_fail++;
      $display("FAIL par_good: got %0d/%h want 1/07",
               n_acc - s_acc, last_data);
    end
  endtask
`endif

  task automatic test_reset_mid();
    rx = 1'b0;
    repeat (880) @(negedge clk);
    n_checks++;
    if (dut.state_q !== DATA) begin
      n_fail++;
      $display("FAIL rmid_state: got %0d want DATA", dut.state_q);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({rx_valid, rx_data, frame_err, parity_err, overrun_err} !== '0) begin
      n_fail++;
      $display("FAIL rmid_outs: got %b/%h/%b want all 0",
               rx_valid, rx_data, {frame_err, parity_err, overrun_err});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    snap();
    repeat (2000) @(negedge clk);
    n_checks++;
    if (n_vh - s_vh !== 0 || n_fe - s_fe !== 0) begin
      n_fail++;
      $display("FAIL rmid_low: got %0d/%0d want 0/0",
               n_vh - s_vh, n_fe - s_fe);
    end
    rx = 1'b1;
    repeat (200) @(negedge clk);
    snap();
    send_frame(8'h5A, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    n_checks++;
    if (n_acc - s_acc !== 1 || last_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL rmid_next: got %0d/%h want 1/5a",
               n_acc - s_acc, last_data);
    end
  endtask

  initial begin
    rx = 1'b1;
    rx_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
